// File: rtl/fifo_flop_queue_if.sv
// Handshake bundle for fifo_flop_queue: write data/request, read request,
// and the head word plus status flags coming back from the queue.
interface fifo_flop_queue_if #(
    parameter int bits = 32
);
    logic [bits-1:0] Din;
    logic            push;
    logic            pop;
    logic [bits-1:0] Dout;
    logic            full;
    logic            pndng;

    // Producer/consumer side: drives requests, observes head and flags
    modport master (
        output Din, push, pop,
        input  Dout, full, pndng
    );

    // Queue side: accepts requests, presents head and flags
    modport slave (
        input  Din, push, pop,
        output Dout, full, pndng
    );
endinterface

// File: rtl/fifo_flop_queue.sv
// Single-clock flop-based FIFO with first-word fall-through.
// Storage is a bank of flops; the head word is mux-selected by the read
// pointer and forced to zero while the queue is empty.
module fifo_flop_queue #(
    parameter int bits  = 32,
    parameter int depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_flop_queue_if.slave bus
);
    localparam int          AW      = $clog2(depth);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

    // Occupancy; one bit wider than the pointers so "full" is distinguishable
    logic [AW:0]     count;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [bits-1:0] mem_reg [depth];

    logic full_int;
    logic pndng_int;
    logic pop_ok;
    logic push_ok;

    // Flags come only from the registered count, so no request-to-output path
    assign full_int  = (count == DEPTH_C);
    assign pndng_int = (count != '0);

    // A pop frees the head slot this cycle, which lets a push land even when full
    assign pop_ok  = bus.pop && pndng_int;
    assign push_ok = bus.push && (!full_int || pop_ok);

    assign bus.full  = full_int;
    assign bus.pndng = pndng_int;
    assign bus.Dout  = pndng_int ? mem_reg[rd_ptr_reg] : '0;

    // Storage bank: clear everything on reset, otherwise write the tail slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push_ok) begin
            mem_reg[wr_ptr_reg] <= bus.Din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_flop_queue.sv
// Self-checking bench for fifo_flop_queue: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_fifo_flop_queue;
    localparam int BITS  = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [BITS-1:0] mq[$];

    fifo_flop_queue_if #(.bits(BITS)) bus ();

    fifo_flop_queue #(.bits(BITS), .depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected {Dout, full, pndng, count} from the reference queue
    function automatic logic [BITS+6:0] exp_vec();
        logic [BITS-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        return {head, mq.size() == DEPTH, mq.size() != 0, 5'(mq.size())};
    endfunction

    // Observed {Dout, full, pndng, count} from the design
    function automatic logic [BITS+6:0] obs_vec();
        return {bus.Dout, bus.full, bus.pndng, dut.count};
    endfunction

    // One clock: drive requests, advance the model at the edge, settle past it
    task automatic step(input bit p, input bit o, input logic [BITS-1:0] d, input bit r);
        bit pa, qa;
        bus.push = p;
        bus.pop  = o;
        bus.Din  = d;
        rst      = r;
        @(posedge clk);
        qa = o && (mq.size() != 0);
        pa = p && ((mq.size() < DEPTH) || qa);
        if (r) begin
            mq.delete();
        end else begin
            if (qa) void'(mq.pop_front());
            if (pa) mq.push_back(d);
        end
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h1234, 1'b1);
        checks++;
        if (obs_vec() !== {{BITS{1'b0}}, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs_vec(), {{BITS{1'b0}}, 7'd0});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, i, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.full !== 1'b1 || dut.count !== 5'd16 || bus.Dout !== 32'd0) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d dout=%h want 1/16/0", bus.full, dut.count, bus.Dout);
        end
    endtask

    task automatic test_full_then_drain();
        step(1'b1, 1'b0, 32'd99, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || dut.count !== 5'd16) begin
            errors++;
            $display("FAIL push_when_full: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.Dout !== BITS'(i)) begin
                errors++;
                $display("FAIL drain_head[%0d]: got %h want %h", i, bus.Dout, i);
            end
            step(1'b0, 1'b1, '0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.pndng !== 1'b0 || bus.Dout !== 32'd0) begin
            errors++;
            $display("FAIL drain_empty: pndng=%b dout=%h want 0/0", bus.pndng, bus.Dout);
        end
    endtask

    task automatic test_empty_pop_and_simul();
        step(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.Dout !== 32'd0) begin
            errors++;
            $display("FAIL pop_empty: got %h want %h", obs_vec(), exp_vec());
        end
        for (int v = 7; v <= 9; v++) step(1'b1, 1'b0, v, 1'b0);
        step(1'b1, 1'b1, 32'd10, 1'b0);
        checks++;
        if (bus.Dout !== 32'd8 || dut.count !== 5'd3 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL push_pop: dout=%h count=%0d want 8/3", bus.Dout, dut.count);
        end
        for (int v = 8; v <= 10; v++) begin
            checks++;
            if (bus.Dout !== BITS'(v)) begin
                errors++;
                $display("FAIL simul_drain: got %h want %h", bus.Dout, v);
            end
            step(1'b0, 1'b1, '0, 1'b0);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'hAA00 + i, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 100 + i, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.Dout !== BITS'(100 + i) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h want %h", i, bus.Dout, 100 + i);
            end
            step(1'b0, 1'b1, '0, 1'b0);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h500 + i, 1'b0);
        step(1'b1, 1'b1, 32'hBEEF, 1'b0);
        checks++;
        if (dut.count !== 5'd16 || bus.Dout !== 32'h501 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d dout=%h want 16/501", dut.count, bus.Dout);
        end
        while (mq.size() != 0) begin
            step(1'b0, 1'b1, '0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_drain: got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h30 + i, 1'b0);
        step(1'b1, 1'b1, 32'h77, 1'b1);
        checks++;
        if (obs_vec() !== {{BITS{1'b0}}, 7'd0}) begin
            errors++;
            $display("FAIL mid_reset: got %h want 0", obs_vec());
        end
        step(1'b1, 1'b0, 32'hA5, 1'b0);
        checks++;
        if (bus.Dout !== 32'hA5 || dut.count !== 5'd1 || bus.pndng !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_push: dout=%h count=%0d want A5/1", bus.Dout, dut.count);
        end
        step(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i < 300) ? 65 : 35;
            step($urandom_range(99) < bias, $urandom_range(99) < (100 - bias),
                 $urandom, $urandom_range(63) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.Din  = '0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_full_then_drain();
        test_empty_pop_and_simul();
        test_wrap();
        test_full_push_pop();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
